wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Writeback stage, directly downstream of the mem stage. Registers the mem stage outputs (load data, ALU result, ALU address) and selects the writeback value. Performs load byte/half extraction and sign/zero extension, then writes the 32-entry register file. Provides the decode stage's two read ports with same-cycle bypass, plus a forwarding tap and a retired-instruction counter.

Parameters:
D_SIZE, 32, data/register width
REG_NUM, 32, number of architectural registers
REG_ADDR, 5, register index width (log2 REG_NUM)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
valid_in  input  1  mem stage presents a valid instruction
stall_in  input  1  hazard unit hold; stage register keeps its value
wb_en_in  input  1  instruction writes a register
mem_to_reg_in  input  1  1 = write load data, 0 = write ALU result
load_size_in  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
load_unsigned_in  input  1  1 = zero-extend, 0 = sign-extend
rd_in  input  REG_ADDR  destination register
read_data_in  input  D_SIZE  mem stage read_data
alu_out_in  input  32  mem stage alu_out_f_mem_2_wb
alu_add_in  input  32  mem stage alu_add_f_mem_2_wb (byte address; bits [1:0] select lane)
rs1_addr  input  REG_ADDR  decode read port 1 address
rs2_addr  input  REG_ADDR  decode read port 2 address
rs1_data  output  D_SIZE  read port 1 data (combinational)
rs2_data  output  D_SIZE  read port 2 data (combinational)
fwd_valid  output  1  stage register holds a pending write
fwd_rd  output  REG_ADDR  pending write destination
fwd_data  output  D_SIZE  pending write value
retired  output  32  count of retired instructions

Behaviour:
- Reset (reset==0, asynchronous): all registers in the file = 0, stage register cleared (fwd_valid=0, fwd_rd=0, fwd_data=0), retired=0. Reset asserted mid-operation discards the pending write.
- Capture at posedge: if stall_in==1, hold. Else stage_valid<=valid_in; stage_rd<=rd_in; stage_we<=valid_in&wb_en_in&(rd_in!=0); stage_data<=selected value.
- Value select: mem_to_reg_in==0 → alu_out_in. Else lane = alu_add_in[1:0]. Byte: read_data_in[8*lane+7:8*lane]. Half: read_data_in[16*lane[1]+15:16*lane[1]]; lane[0] is ignored (no misalignment trap). Word: full. Extend to D_SIZE per load_unsigned_in.
- Register write: on every posedge with stall_in==0 and stage_we==1, reg[stage_rd]<=stage_data. This happens in the same edge as the next capture. Latency: input at edge N, register updated at edge N+1.
- Stall: no regfile write and no retire increment while stall_in==1. The pending write stays visible on the forwarding tap.
- x0: always reads 0. Writes to rd=0 are never enabled.
- Read ports: if stage_we && rsX_addr==stage_rd, return stage_data (bypass). Else return reg[rsX_addr]. Both ports are independent, and the same address on both ports is legal.
- fwd_valid=stage_we, fwd_rd=stage_rd, fwd_data=stage_data.
- retired increments by 1 on each edge where stall_in==0 and stage_valid==1, whether or not the instruction writes a register. It wraps from 0xFFFFFFFF to 0.
- Simultaneous events: a write to register R and a read of R in the same cycle return the new value via bypass. Back-to-back writes to the same rd: the later one wins.

Decomposition:
- Shared package (struct.sv): D_SIZE, REG_NUM, REG_ADDR, load-size encodings (LS_BYTE/LS_HALF/LS_WORD), and a wb_pkt_t struct {valid, we, rd, data}.
- One sub-module: regfile (REG_NUM x D_SIZE, one write port, two combinational read ports, x0 hardwired, async active-low clear). wb_stage owns the capture, extraction, bypass and counter logic.

Test Plan:
- Reset mid-write: write rd=5, data 0x1234 captured, then reset=0 before the next edge → rs1_addr=5 reads 0, fwd_valid=0, retired=0.
- ALU writeback: valid_in=1, wb_en_in=1, mem_to_reg_in=0, rd_in=3, alu_out_in=0xDEADBEEF → cycle N+1 rs1_data(3)=0xDEADBEEF via bypass, and still 0xDEADBEEF after edge N+1 from the file; retired=1.
- Load extraction: read_data_in=0x80FF7F01. Byte lane 3 signed → 0xFFFFFF80. Byte lane 2 unsigned → 0x000000FF. Half lane 2 signed → 0xFFFF80FF. Half lane 0 unsigned → 0x00007F01.
- x0 protection: wb_en_in=1, rd_in=0, alu_out_in=0xFFFFFFFF → rs1_data(0)=0, fwd_valid=0, but retired still increments.
- Stall: capture rd=7 value 0x55, hold stall_in=1 for 3 cycles → reg7 stays old (bypass still shows 0x55), retired unchanged. On release, reg7=0x55 and retired increments once.
- Counter wrap / back-to-back writes: force retired to 0xFFFFFFFF via 2^32-1 retires (or backdoor) → next retire gives 0. Consecutive writes rd=9 of 0x1 then 0x2 → rs2_data(9)=0x2.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: widths, load-size encodings,
// the stage-register packet and the load lane extraction helper.
package wb_stage_pkg;

  localparam int D_SIZE   = 32;
  localparam int REG_NUM  = 32;
  localparam int REG_ADDR = 5;

  // Load size encodings; the reserved code behaves like a full word.
  typedef enum logic [1:0] {
    LS_BYTE = 2'b00,
    LS_HALF = 2'b01,
    LS_WORD = 2'b10,
    LS_RSVD = 2'b11
  } load_size_e;

  // Contents of the stage register: one pending writeback.
  typedef struct packed {
    logic                valid;
    logic                we;
    logic [REG_ADDR-1:0] rd;
    logic [D_SIZE-1:0]   data;
  } wb_pkt_t;

  // Pick the addressed byte/half out of the loaded word and extend it.
  // Halves use only lane[1]; an odd lane is not trapped, it simply maps to
  // the half that contains it.
  function automatic logic [D_SIZE-1:0] load_extract(
    input logic [D_SIZE-1:0] rdata,
    input logic [1:0]        lane,
    input logic [1:0]        size,
    input logic              uns
  );
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [D_SIZE-1:0] res;
    case (lane)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = lane[1] ? rdata[31:16] : rdata[15:0];
    case (load_size_e'(size))
      LS_BYTE: res = {{(D_SIZE-8){~uns & byte_v[7]}}, byte_v};
      LS_HALF: res = {{(D_SIZE-16){~uns & half_v[15]}}, half_v};
      default: res = rdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Bundle of the mem-stage inputs, decode read ports, forwarding tap and
// retire counter of the writeback stage.
//
// Handshake: there is no backpressure towards the mem stage. valid_in
// qualifies the instruction fields in the cycle it is high; stall_in from
// the hazard unit freezes the stage register, the register file write and
// the retire counter for that cycle; the instruction presented while stall_in
// is high is not taken.
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic                valid_in;
  logic                stall_in;
  logic                wb_en_in;
  logic                mem_to_reg_in;
  logic [1:0]          load_size_in;
  logic                load_unsigned_in;
  logic [REG_ADDR-1:0] rd_in;
  logic [D_SIZE-1:0]   read_data_in;
  logic [31:0]         alu_out_in;
  logic [31:0]         alu_add_in;
  logic [REG_ADDR-1:0] rs1_addr;
  logic [REG_ADDR-1:0] rs2_addr;
  logic [D_SIZE-1:0]   rs1_data;
  logic [D_SIZE-1:0]   rs2_data;
  logic                fwd_valid;
  logic [REG_ADDR-1:0] fwd_rd;
  logic [D_SIZE-1:0]   fwd_data;
  logic [31:0]         retired;

  // Writeback stage side.
  modport slave (
    input  valid_in, stall_in, wb_en_in, mem_to_reg_in, load_size_in,
           load_unsigned_in, rd_in, read_data_in, alu_out_in, alu_add_in,
           rs1_addr, rs2_addr,
    output rs1_data, rs2_data, fwd_valid, fwd_rd, fwd_data, retired
  );

  // Mem stage / decode / hazard unit side.
  modport master (
    output valid_in, stall_in, wb_en_in, mem_to_reg_in, load_size_in,
           load_unsigned_in, rd_in, read_data_in, alu_out_in, alu_add_in,
           rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, fwd_valid, fwd_rd, fwd_data, retired
  );

endinterface

// File: rtl/wb_stage_regfile.sv
// Architectural register file: one write port, two combinational read
// ports, x0 reads as zero and is never written, asynchronous clear.
module wb_stage_regfile
  import wb_stage_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                we_i,
  input  logic [REG_ADDR-1:0] waddr_i,
  input  logic [D_SIZE-1:0]   wdata_i,
  input  logic [REG_ADDR-1:0] raddr1_i,
  input  logic [REG_ADDR-1:0] raddr2_i,
  output logic [D_SIZE-1:0]   rdata1_o,
  output logic [D_SIZE-1:0]   rdata2_o
);

  logic [D_SIZE-1:0] mem_q [REG_NUM];

  // Storage: cleared on reset, written when enabled for a non-zero index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_NUM; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports: x0 is forced to zero independent of storage contents.
  always_comb begin
    rdata1_o = '0;
    rdata2_o = '0;
    if (raddr1_i != '0) rdata1_o = mem_q[raddr1_i];
    if (raddr2_i != '0) rdata2_o = mem_q[raddr2_i];
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers the mem-stage result, selects and extends the
// writeback value, writes the register file one edge later, bypasses the
// pending write onto the decode read ports and counts retired instructions.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  wb_stage_if.slave bus
);

  wb_pkt_t           stage_q, stage_d;
  logic [31:0]       retired_q, retired_d;
  logic              retire_en;
  logic              rf_we;
  logic [D_SIZE-1:0] rf_rdata1, rf_rdata2;
  logic [D_SIZE-1:0] sel_value;
  logic              unused_addr_hi;

  // Only the lane bits of the address matter to this stage.
  assign unused_addr_hi = ^bus.alu_add_in[31:2];

  // Writeback value select: ALU result or extracted/extended load data.
  always_comb begin
    sel_value = bus.alu_out_in;
    if (bus.mem_to_reg_in) begin
      sel_value = load_extract(bus.read_data_in, bus.alu_add_in[1:0],
                               bus.load_size_in, bus.load_unsigned_in);
    end
  end

  // Stage register next state: hold under stall, otherwise take the
  // incoming instruction; writes to x0 are never enabled.
  always_comb begin
    stage_d = stage_q;
    if (!bus.stall_in) begin
      stage_d.valid = bus.valid_in;
      stage_d.we    = bus.valid_in & bus.wb_en_in & (bus.rd_in != '0);
      stage_d.rd    = bus.rd_in;
      stage_d.data  = sel_value;
    end
  end

  // Stage register; reset discards any pending write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // The pending write commits on the same edge that captures the next one.
  assign rf_we     = ~bus.stall_in & stage_q.we;
  assign retire_en = ~bus.stall_in & stage_q.valid;
  assign retired_d = retired_q + 32'd1;

  // Retire counter: one per unstalled edge with a valid instruction, wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else if (retire_en) begin
      retired_q <= retired_d;
    end
  end

  wb_stage_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we_i     (rf_we),
    .waddr_i  (stage_q.rd),
    .wdata_i  (stage_q.data),
    .raddr1_i (bus.rs1_addr),
    .raddr2_i (bus.rs2_addr),
    .rdata1_o (rf_rdata1),
    .rdata2_o (rf_rdata2)
  );

  // Read ports with bypass of the pending write, so a same-cycle write and
  // read of a register return the new value.
  always_comb begin
    bus.rs1_data = rf_rdata1;
    bus.rs2_data = rf_rdata2;
    if (stage_q.we && (bus.rs1_addr == stage_q.rd)) bus.rs1_data = stage_q.data;
    if (stage_q.we && (bus.rs2_addr == stage_q.rd)) bus.rs2_data = stage_q.data;
  end

  // Forwarding tap and counter outputs.
  always_comb begin
    bus.fwd_valid = stage_q.we;
    bus.fwd_rd    = stage_q.rd;
    bus.fwd_data  = stage_q.data;
    bus.retired   = retired_q;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios with a scoreboard of
// expected forwarding-tap contents pushed when an instruction is driven.
module tb_wb_stage;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  logic [37:0] exp_q[$];

  wb_stage_if bus ();

  wb_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent model of the writeback value.
  function automatic logic [31:0] model_value(input logic m2r, input logic [1:0] ls,
                                               input logic uns, input logic [31:0] rdata,
                                               input logic [31:0] alu, input logic [31:0] addr);
    logic [31:0] x;
    if (!m2r) return alu;
    if (ls == 2'b00) begin
      x = (rdata >> (8 * addr[1:0])) & 32'h0000_00FF;
      if (!uns && x[7]) x = x | 32'hFFFF_FF00;
    end else if (ls == 2'b01) begin
      x = (rdata >> (16 * addr[1])) & 32'h0000_FFFF;
      if (!uns && x[15]) x = x | 32'hFFFF_0000;
    end else begin
      x = rdata;
    end
    return x;
  endfunction

  // Drivers
  task automatic drive_instr(input logic v, input logic we, input logic m2r,
                             input logic [1:0] ls, input logic uns, input logic [4:0] rd,
                             input logic [31:0] rdata, input logic [31:0] alu,
                             input logic [31:0] addr);
    logic exp_we;
    bus.valid_in         = v;
    bus.wb_en_in         = we;
    bus.mem_to_reg_in    = m2r;
    bus.load_size_in     = ls;
    bus.load_unsigned_in = uns;
    bus.rd_in            = rd;
    bus.read_data_in     = rdata;
    bus.alu_out_in       = alu;
    bus.alu_add_in       = addr;
    exp_we = v & we & (rd != 5'd0);
    exp_q.push_back({exp_we, rd, model_value(m2r, ls, uns, rdata, alu, addr)});
  endtask

  task automatic drive_idle();
    bus.valid_in         = 1'b0;
    bus.wb_en_in         = 1'b0;
    bus.mem_to_reg_in    = 1'b0;
    bus.load_size_in     = 2'b00;
    bus.load_unsigned_in = 1'b0;
    bus.rd_in            = 5'd0;
    bus.read_data_in     = 32'h0;
    bus.alu_out_in       = 32'h0;
    bus.alu_add_in       = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.stall_in = 1'b0;
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd31;
    drive_idle();
    repeat (3) tick();
    n_vec++;
    if ({bus.fwd_valid, bus.fwd_rd, bus.fwd_data} !== 38'h0) begin
      n_err++;
      $display("FAIL reset_fwd got=%h exp=%h", {bus.fwd_valid, bus.fwd_rd, bus.fwd_data}, 38'h0);
    end
    n_vec++;
    if (bus.retired !== 32'h0) begin
      n_err++;
      $display("FAIL reset_retired got=%h exp=%h", bus.retired, 32'h0);
    end
    n_vec++;
    if (bus.rs1_data !== 32'h0 || bus.rs2_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rs got=%h/%h exp=0/0", bus.rs1_data, bus.rs2_data);
    end
    reset = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    logic [37:0] exp;
    drive_instr(1, 1, 0, 2'b10, 0, 5'd5, 32'h0, 32'h0000_1234, 32'h0);
    tick();
    exp = exp_q.pop_front();
    n_vec++;
    if ({bus.fwd_valid, bus.fwd_rd, bus.fwd_data} !== exp) begin
      n_err++;
      $display("FAIL midrst_capture got=%h exp=%h", {bus.fwd_valid, bus.fwd_rd, bus.fwd_data}, exp);
    end
    drive_idle();
    reset = 1'b0;
    #2;
    n_vec++;
    if (bus.rs1_data !== 32'h0 || bus.fwd_valid !== 1'b0 || bus.retired !== 32'h0) begin
      n_err++;
      $display("FAIL midrst_async got rs1=%h fv=%b ret=%h exp=0/0/0", bus.rs1_data, bus.fwd_valid, bus.retired);
    end
    tick();
    reset = 1'b1;
    tick();
    n_vec++;
    if (bus.rs1_data !== 32'h0) begin
      n_err++;
      $display("FAIL midrst_discard got=%h exp=%h", bus.rs1_data, 32'h0);
    end
  endtask

  task automatic test_alu_wb();
    logic [37:0] exp;
    bus.rs1_addr = 5'd3;
    drive_instr(1, 1, 0, 2'b00, 0, 5'd3, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0);
    tick();
    exp = exp_q.pop_front();
    n_vec++;
    if ({bus.fwd_valid, bus.fwd_rd, bus.fwd_data} !== exp) begin
      n_err++;
      $display("FAIL alu_fwd got=%h exp=%h", {bus.fwd_valid, bus.fwd_rd, bus.fwd_data}, exp);
    end
    n_vec++;
    if (bus.rs1_data !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL alu_bypass got=%h exp=%h", bus.rs1_data, 32'hDEAD_BEEF);
    end
    drive_idle();
    tick();
    n_vec++;
    if (bus.rs1_data !== 32'hDEAD_BEEF || bus.fwd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL alu_file got=%h fv=%b exp=%h fv=0", bus.rs1_data, bus.fwd_valid, 32'hDEAD_BEEF);
    end
    n_vec++;
    if (bus.retired !== 32'd1) begin
      n_err++;
      $display("FAIL alu_retired got=%0d exp=%0d", bus.retired, 1);
    end
  endtask

  task automatic test_load_extract();
    logic [1:0]  ls_t [7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11};
    logic        un_t [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  ln_t [7] = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0};
    logic [31:0] ex_t [7] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01,
                              32'hFFFF_80FF, 32'h80FF_7F01, 32'h80FF_7F01};
    logic [37:0] exp;
    for (int i = 0; i < 7; i++) begin
      bus.rs1_addr = 5'(10 + i);
      drive_instr(1, 1, 1, ls_t[i], un_t[i], 5'(10 + i), 32'h80FF_7F01, 32'hA5A5_A5A5,
                  32'h1000_0000 | 32'(ln_t[i]));
      tick();
      exp = exp_q.pop_front();
      n_vec++;
      if ({bus.fwd_valid, bus.fwd_rd, bus.fwd_data} !== exp || bus.fwd_data !== ex_t[i]) begin
        n_err++;
        $display("FAIL load_case%0d got=%h exp=%h", i, bus.fwd_data, ex_t[i]);
      end
      n_vec++;
      if (bus.rs1_data !== ex_t[i]) begin
        n_err++;
        $display("FAIL load_bypass%0d got=%h exp=%h", i, bus.rs1_data, ex_t[i]);
      end
    end
    drive_idle();
    bus.rs1_addr = 5'd10;
    bus.rs2_addr = 5'd16;
    tick();
    n_vec++;
    if (bus.rs1_data !== 32'hFFFF_FF80 || bus.rs2_data !== 32'h80FF_7F01) begin
      n_err++;
      $display("FAIL load_file got=%h/%h exp=ffffff80/80ff7f01", bus.rs1_data, bus.rs2_data);
    end
    n_vec++;
    if (bus.retired !== 32'd8) begin
      n_err++;
      $display("FAIL load_retired got=%0d exp=%0d", bus.retired, 8);
    end
  endtask

  task automatic test_x0();
    logic [37:0] exp;
    bus.rs1_addr = 5'd0;
    drive_instr(1, 1, 0, 2'b00, 0, 5'd0, 32'h0, 32'hFFFF_FFFF, 32'h0);
    tick();
    exp = exp_q.pop_front();
    n_vec++;
    if ({bus.fwd_valid, bus.fwd_rd, bus.fwd_data} !== exp || bus.rs1_data !== 32'h0) begin
      n_err++;
      $display("FAIL x0_capture got fwd=%h rs1=%h exp fwd=%h rs1=0",
               {bus.fwd_valid, bus.fwd_rd, bus.fwd_data}, bus.rs1_data, exp);
    end
    drive_idle();
    tick();
    n_vec++;
    if (bus.rs1_data !== 32'h0 || bus.retired !== 32'd9) begin
      n_err++;
      $display("FAIL x0_after got rs1=%h ret=%0d exp rs1=0 ret=9", bus.rs1_data, bus.retired);
    end
  endtask

  task automatic test_stall();
    logic [37:0] exp;
    bus.rs1_addr = 5'd7;
    drive_instr(1, 1, 0, 2'b00, 0, 5'd7, 32'h0, 32'h0000_0055, 32'h0);
    tick();
    exp = exp_q.pop_front();
    n_vec++;
    if ({bus.fwd_valid, bus.fwd_rd, bus.fwd_data} !== exp) begin
      n_err++;
      $display("FAIL stall_capture got=%h exp=%h", {bus.fwd_valid, bus.fwd_rd, bus.fwd_data}, exp);
    end
    // Offer a different instruction while stalled; it must not be taken.
    bus.stall_in   = 1'b1;
    bus.valid_in   = 1'b1;
    bus.wb_en_in   = 1'b1;
    bus.rd_in      = 5'd8;
    bus.alu_out_in = 32'h0000_0099;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({bus.fwd_valid, bus.fwd_rd, bus.fwd_data} !== {1'b1, 5'd7, 32'h55} ||
          bus.rs1_data !== 32'h55 || bus.retired !== 32'd9) begin
        n_err++;
        $display("FAIL stall_hold%0d got fwd=%h rs1=%h ret=%0d exp fwd=%h rs1=55 ret=9", i,
                 {bus.fwd_valid, bus.fwd_rd, bus.fwd_data}, bus.rs1_data, bus.retired,
                 {1'b1, 5'd7, 32'h55});
      end
    end
    bus.stall_in = 1'b0;
    drive_idle();
    tick();
    n_vec++;
    if (bus.rs1_data !== 32'h55 || bus.fwd_valid !== 1'b0 || bus.retired !== 32'd10) begin
      n_err++;
      $display("FAIL stall_release got rs1=%h fv=%b ret=%0d exp rs1=55 fv=0 ret=10",
               bus.rs1_data, bus.fwd_valid, bus.retired);
    end
    tick();
    n_vec++;
    if (bus.retired !== 32'd10) begin
      n_err++;
      $display("FAIL stall_once got=%0d exp=%0d", bus.retired, 10);
    end
  endtask

  task automatic test_back_to_back();
    logic [37:0] exp;
    bus.rs1_addr = 5'd9;
    bus.rs2_addr = 5'd9;
    for (int i = 1; i <= 2; i++) begin
      drive_instr(1, 1, 0, 2'b00, 0, 5'd9, 32'h0, 32'(i), 32'h0);
      tick();
      exp = exp_q.pop_front();
      n_vec++;
      if ({bus.fwd_valid, bus.fwd_rd, bus.fwd_data} !== exp || bus.rs2_data !== 32'(i)) begin
        n_err++;
        $display("FAIL b2b_write%0d got fwd=%h rs2=%h exp fwd=%h rs2=%h", i,
                 {bus.fwd_valid, bus.fwd_rd, bus.fwd_data}, bus.rs2_data, exp, 32'(i));
      end
    end
    drive_idle();
    tick();
    n_vec++;
    if (bus.rs2_data !== 32'h2 || bus.rs1_data !== 32'h2) begin
      n_err++;
      $display("FAIL b2b_file got=%h/%h exp=2/2", bus.rs1_data, bus.rs2_data);
    end
    n_vec++;
    if (bus.retired !== 32'd12) begin
      n_err++;
      $display("FAIL b2b_retired got=%0d exp=%0d", bus.retired, 12);
    end
  endtask

  task automatic test_wrap();
    logic [37:0] exp;
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    drive_instr(1, 0, 0, 2'b00, 0, 5'(1 + $urandom_range(0, 30)), 32'h0,
                32'($urandom_range(0, 32'h7FFF_FFFF)), 32'h0);
    tick();
    exp = exp_q.pop_front();
    n_vec++;
    if ({bus.fwd_valid, bus.fwd_rd, bus.fwd_data} !== exp || bus.retired !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL wrap_pre got fwd=%h ret=%h exp fwd=%h ret=ffffffff",
               {bus.fwd_valid, bus.fwd_rd, bus.fwd_data}, bus.retired, exp);
    end
    drive_idle();
    tick();
    n_vec++;
    if (bus.retired !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_zero got=%h exp=%h", bus.retired, 32'h0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_reset_mid_write();
    test_alu_wb();
    test_load_extract();
    test_x0();
    test_stall();
    test_back_to_back();
    test_wrap();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_left got=%0d exp=%0d", exp_q.size(), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
